obs_b2_mul_scheduler: RTL and testbench

//  Sequences one 42x42-bit GF(2) polynomial multiply (OBS level-4 datapath) over a single shared 21x21 sub-multiplier.

---
 rtl/obs_pkg.sv | 50 +++++
 rtl/obs_b2_mul_scheduler.sv | 112 +++++++++++
 tb/tb_obs_b2_mul_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obs_pkg.sv
// Shared constants, FSM state type and GF(2) helpers for the OBS level-4 multiply path.
// obs_combine is also used by the combinational L4 datapath.
package obs_pkg;

    localparam int N    = 42;
    localparam int HALF = N / 2;
    localparam int PW   = 2 * HALF - 1;
    localparam int OW   = 2 * N - 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMBINE,
        DONE
    } state_t;

    // Coefficients at even powers: v[0], v[2], v[4], ...
    function automatic logic [HALF-1:0] obs_even(input logic [N-1:0] v);
        logic [HALF-1:0] r;
        for (int i = 0; i < HALF; i++) r[i] = v[2*i];
        return r;
    endfunction

    // Coefficients at odd powers: v[1], v[3], v[5], ...
    function automatic logic [HALF-1:0] obs_odd(input logic [N-1:0] v);
        logic [HALF-1:0] r;
        for (int i = 0; i < HALF; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    // A*B = P1(x^2) + x*(P2+P3)(x^2) + x^2*P4(x^2): even bit 2j gets P1[j]^P4[j-1],
    // odd bit 2j+1 gets P2[j]^P3[j].
    function automatic logic [OW-1:0] obs_combine(
        input logic [PW-1:0] p1,
        input logic [PW-1:0] p2,
        input logic [PW-1:0] p3,
        input logic [PW-1:0] p4
    );
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < PW; j++) begin
            r[2*j]   = r[2*j]   ^ p1[j];
            r[2*j+1] = r[2*j+1] ^ p2[j] ^ p3[j];
            r[2*j+2] = r[2*j+2] ^ p4[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/obs_b2_mul_scheduler.sv
// Runs one 42x42 GF(2) multiply as four serial 21x21 sub-products on a shared multiplier,
// then interleaves the buffered sub-products into the 83-bit result.
module obs_b2_mul_scheduler
    import obs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    output logic            sm_req_valid,
    input  logic            sm_req_ready,
    output logic [HALF-1:0] sm_req_x,
    output logic [HALF-1:0] sm_req_y,
    input  logic            sm_rsp_valid,
    input  logic [PW-1:0]   sm_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic            busy,
    output logic            err_stray
);

    state_t          state;
    logic [1:0]      k;
    logic [HALF-1:0] a_e, a_o, b_e, b_o;
    logic [PW-1:0]   slot [4];
    logic [1:0]      k_next;

    assign k_next = k + 2'd1;

    // NOTE: every register here, outputs included, is updated with <= from one always_ff so
    // all reads within a cycle see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= 2'd0;
            a_e          <= '0;
            a_o          <= '0;
            b_e          <= '0;
            b_o          <= '0;
            in_ready     <= 1'b1;
            sm_req_valid <= 1'b0;
            sm_req_x     <= '0;
            sm_req_y     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            err_stray    <= 1'b0;
            // NOTE: the slot buffer is small and must read as zero after reset, so it is
            // reset explicitly rather than left as an unreset RAM-style array.
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else begin
            if (sm_rsp_valid && state != WAIT) err_stray <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_e          <= obs_even(in_a);
                        a_o          <= obs_odd(in_a);
                        b_e          <= obs_even(in_b);
                        b_o          <= obs_odd(in_b);
                        k            <= 2'd0;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        sm_req_valid <= 1'b1;
                        sm_req_x     <= obs_even(in_a);
                        sm_req_y     <= obs_even(in_b);
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sm_req_ready) begin
                        sm_req_valid <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (sm_rsp_valid) begin
                        slot[k] <= sm_rsp_data;
                        if (k == 2'd3) begin
                            state <= COMBINE;
                        end else begin
                            // Sub-product order: (Ae,Be) (Ae,Bo) (Ao,Be) (Ao,Bo)
                            k            <= k_next;
                            sm_req_valid <= 1'b1;
                            sm_req_x     <= k_next[1] ? a_o : a_e;
                            sm_req_y     <= k_next[0] ? b_o : b_e;
                            state        <= ISSUE;
                        end
                    end
                end
                COMBINE: begin
                    out_data  <= obs_combine(slot[0], slot[1], slot[2], slot[3]);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obs_b2_mul_scheduler.sv
// Randomised bench for obs_b2_mul_scheduler against a direct carry-less multiply model,
// with a responding shared-multiplier model and directed corner cases.
module tb_obs_b2_mul_scheduler;
    import obs_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_a, in_b;
    logic            sm_req_valid;
    logic            sm_req_ready;
    logic [HALF-1:0] sm_req_x, sm_req_y;
    logic            sm_rsp_valid;
    logic [PW-1:0]   sm_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            busy;
    logic            err_stray;

    obs_b2_mul_scheduler dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .sm_req_valid(sm_req_valid), .sm_req_ready(sm_req_ready),
        .sm_req_x(sm_req_x), .sm_req_y(sm_req_y),
        .sm_rsp_valid(sm_rsp_valid), .sm_rsp_data(sm_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference model: plain carry-less products and the even/odd split by definition.
    function automatic logic [OW-1:0] clmul_full(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [OW-1:0] r = '0;
        for (int i = 0; i < N; i++) if (a[i]) r ^= ({{(OW-N){1'b0}}, b} << i);
        return r;
    endfunction

    function automatic logic [PW-1:0] clmul_half(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
        logic [PW-1:0] r = '0;
        for (int i = 0; i < HALF; i++) if (a[i]) r ^= ({{(PW-HALF){1'b0}}, b} << i);
        return r;
    endfunction

    function automatic logic [HALF-1:0] split(input logic [N-1:0] v, input bit odd);
        logic [HALF-1:0] r;
        for (int i = 0; i < HALF; i++) r[i] = v[2*i + (odd ? 1 : 0)];
        return r;
    endfunction

    // Job bookkeeping owned by the driver
    logic [N-1:0]  cur_a = '0, cur_b = '0;
    logic [OW-1:0] exp_prod = '0;
    int            job_id = 0;
    int            acc_cyc = 0;
    int            jobs_accepted = 0;
    bit            lat_check = 1;
    bit            rand_ready = 0;
    bit            rand_out = 0;
    bit            hold_out = 0;
    int            max_delay = 0;
    int            fixed_delay = 0;

    // Shared-multiplier model: random accept, 0..max_delay extra cycles of response latency.
    logic [HALF-1:0] seen_x [4];
    logic [HALF-1:0] seen_y [4];
    int              hs_k = 0;
    int              my_job = -1;
    bit              pend = 0;
    int              cd = 0;
    logic [PW-1:0]   pend_data = '0;
    bit              stall_prev = 0;
    logic [HALF-1:0] stall_x = '0, stall_y = '0;

    always @(negedge clk) begin
        sm_rsp_valid = 1'b0;
        if (pend) begin
            if (cd == 0) begin
                sm_rsp_valid = 1'b1;
                sm_rsp_data  = pend_data;
                pend         = 0;
            end else begin
                cd--;
            end
        end
        if (my_job != job_id) begin
            my_job = job_id;
            hs_k   = 0;
        end
        if (rst) begin
            stall_prev   = 0;
            sm_req_ready = 1'b0;
        end else begin
            if (stall_prev) begin
                check("req_valid_held", sm_req_valid, 1'b1);
                check("req_x_stable", sm_req_x, stall_x);
                check("req_y_stable", sm_req_y, stall_y);
            end
            sm_req_ready = rand_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
            stall_prev = 0;
            if (sm_req_valid) begin
                if (sm_req_ready) begin
                    if (hs_k > 3) begin
                        timeout("extra_sub_request");
                    end else begin
                        check("req_x", sm_req_x, split(cur_a, hs_k >= 2));
                        check("req_y", sm_req_y, split(cur_b, hs_k % 2 == 1));
                        seen_x[hs_k] = sm_req_x;
                        seen_y[hs_k] = sm_req_y;
                    end
                    hs_k++;
                    pend      = 1;
                    cd        = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(max_delay, 0));
                    pend_data = clmul_half(sm_req_x, sm_req_y);
                end else begin
                    stall_prev = 1;
                    stall_x    = sm_req_x;
                    stall_y    = sm_req_y;
                end
            end
        end
    end

    // Output-side compare process and consumer.
    int            done_count = 0;
    logic [OW-1:0] last_out = '0;
    bit            pv = 0, pr = 0;
    logic [OW-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv        = 0;
            out_ready = 1'b0;
        end else begin
            check("in_ready_vs_busy", in_ready, !busy);
            if (out_valid) begin
                check("out_data", out_data, exp_prod);
                if (!pv && lat_check) check("latency", cyc - acc_cyc, 10);
            end
            if (pv && !pr) begin
                check("out_valid_held", out_valid, 1'b1);
                check("out_data_held", out_data, pd);
            end
            out_ready = hold_out ? 1'b0 : (rand_out ? 1'($urandom_range(1, 0)) : 1'b1);
            if (out_valid && out_ready) begin
                done_count++;
                last_out = out_data;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic start_job(input logic [N-1:0] a, input logic [N-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int t = 0; t < 500 && !in_ready; t++) @(negedge clk);
        if (!in_ready) begin
            timeout("accept");
            in_valid = 1'b0;
            return;
        end
        cur_a    = a;
        cur_b    = b;
        exp_prod = clmul_full(a, b);
        acc_cyc  = cyc;
        job_id++;
        jobs_accepted++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 1000 && done_count < jobs_accepted; t++) @(negedge clk);
        if (done_count < jobs_accepted) begin
            timeout("job_done");
            jobs_accepted = done_count;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_req_valid"}, sm_req_valid, 1'b0);
        check({tag, "_req_x"}, sm_req_x, '0);
        check({tag, "_req_y"}, sm_req_y, '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [N-1:0]  ra, rb, a2, b2;
    logic [OW-1:0] job1_prod;
    int            d0;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        sm_rsp_data  = '0;
        sm_req_ready = 1'b0;
        sm_rsp_valid = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_err_stray", err_stray, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // A=1, B=1: only P1 is nonzero
        start_job(42'd1, 42'd1);
        wait_done();
        check("one_x_one", last_out, 83'd1);
        check("one_x0", seen_x[0], 21'd1); check("one_y0", seen_y[0], 21'd1);
        check("one_x1", seen_x[1], 21'd1); check("one_y1", seen_y[1], 21'd0);
        check("one_x2", seen_x[2], 21'd0); check("one_y2", seen_y[2], 21'd1);
        check("one_x3", seen_x[3], 21'd0); check("one_y3", seen_y[3], 21'd0);

        // Top bits: only P4 nonzero, landing in out[82]
        ra = 42'h200_0000_0000;
        start_job(ra, ra);
        wait_done();
        check("top_bit", last_out, 83'h4_0000_0000_0000_0000_0000);

        // Squaring all-ones gives every even coefficient
        ra = '1;
        start_job(ra, ra);
        wait_done();
        check("all_ones_sq", last_out, 83'h5_5555_5555_5555_5555_5555);

        // Output stall: result held, second job waits for the drain
        ra = 42'h2AB_CDEF_0123; rb = 42'h155_4321_FEDC;
        a2 = 42'h0F0_F0F0_F0F0; b2 = 42'h333_3333_3333;
        job1_prod = clmul_full(ra, rb);
        hold_out = 1;
        start_job(ra, rb);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        if (!out_valid) timeout("drain_out_valid");
        in_a = a2; in_b = b2; in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, job1_prod);
            check("stall_in_ready", in_ready, 1'b0);
        end
        d0 = done_count;
        hold_out = 0;
        start_job(a2, b2);
        check("drain_before_accept", done_count, d0 + 1);
        wait_done();
        check("drain_job2", last_out, clmul_full(a2, b2));

        // Randomised traffic with request stalls, response delays and output backpressure
        rand_ready  = 1;
        rand_out    = 1;
        fixed_delay = -1;
        max_delay   = 5;
        lat_check   = 0;
        for (int j = 0; j < 1000; j++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (j % 97 == 0) ra = '0;
            start_job(ra, rb);
            wait_done();
        end
        check("no_stray_in_normal_traffic", err_stray, 1'b0);

        // Reset while waiting on sub-product k=2; its late response must flag err_stray
        rand_ready  = 0;
        rand_out    = 0;
        fixed_delay = 4;
        start_job({$urandom, $urandom}, {$urandom, $urandom});
        for (int t = 0; t < 100 && !(hs_k == 3 && !sm_req_valid); t++) @(negedge clk);
        if (!(hs_k == 3 && !sm_req_valid)) timeout("reach_wait_k2");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midjob_reset");
        check("midjob_reset_err_stray", err_stray, 1'b0);
        rst = 1'b0;
        jobs_accepted = done_count;
        repeat (4) @(negedge clk);
        check("stray_after_reset", err_stray, 1'b1);
        check_reset_outputs("post_stray");

        fixed_delay = 0;
        lat_check   = 1;
        ra = 42'h3FF_0000_FFFF; rb = 42'h001_2345_6789;
        start_job(ra, rb);
        wait_done();
        check("job_after_reset", last_out, clmul_full(ra, rb));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
